// File: rtl/mem_stage_wb.sv
// mem_stage_wb: memory-access stage and MEM/WB pipeline register.
// Resolves branches, runs loads/stores over a req/ack data-memory port,
// stalls upstream while an access is outstanding, and registers the
// write-back fields. Optional access timeout: define MEM_TIMEOUT_EN.
module mem_stage_wb #(
  parameter int DW      = 16,
  parameter int RW      = 3,
  parameter int TIMEOUT = 15
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          ZeroIn,
  input  logic [1:0]    WBIn,
  input  logic [2:0]    MIn,
  input  logic [DW-1:0] PcAddIn,
  input  logic [DW-1:0] AluOutIn,
  input  logic [DW-1:0] ReadData2In,
  input  logic [RW-1:0] TRegIn,
  output logic          Stall,
  output logic          PCSrc,
  output logic [DW-1:0] BranchTarget,
  output logic          MemReq,
  output logic          MemWe,
  output logic [DW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic          MemAck,
  input  logic [DW-1:0] MemRData,
  output logic [1:0]    WBOut,
  output logic          ValidOut,
  output logic [DW-1:0] MemDataOut,
  output logic [DW-1:0] AluOutOut,
  output logic [RW-1:0] TRegOut,
  output logic          MemErr
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]    wb_q, wb_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] mem_data_q, mem_data_d;
  logic [DW-1:0] alu_q, alu_d;
  logic [RW-1:0] treg_q, treg_d;
  logic          memop_s;
  logic          stall_s;
  logic          timeout_s;

  assign memop_s = MIn[0] | MIn[1];

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  assign timeout_s = (state_q == S_ACCESS) && !MemAck && (cnt_q == CW'(TIMEOUT));

  // Wait counter: clears when an access is issued, counts unacknowledged ACCESS cycles; error is sticky
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | timeout_s;
    if ((state_q == S_IDLE) && memop_s) begin
      cnt_d = {CW{1'b0}};
    end else if ((state_q == S_ACCESS) && !MemAck && !timeout_s) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Wait counter and sticky error registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= {CW{1'b0}};
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign MemErr = err_q;
`else
  assign timeout_s = 1'b0;
  assign MemErr    = 1'b0;
`endif

  // Next-state, memory request and MEM/WB load decisions
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_d        = 2'b00;
    valid_d     = 1'b0;
    mem_data_d  = mem_data_q;
    alu_d       = alu_q;
    treg_d      = treg_q;
    stall_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (memop_s) begin
          // Issue the access; a bubble enters MEM/WB meanwhile.
          stall_s     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = MIn[1];
          mem_addr_d  = AluOutIn;
          mem_wdata_d = ReadData2In;
          state_d     = S_ACCESS;
        end else begin
          wb_d       = WBIn;
          valid_d    = 1'b1;
          mem_data_d = {DW{1'b0}};
          alu_d      = AluOutIn;
          treg_d     = TRegIn;
        end
      end
      S_ACCESS: begin
        if (MemAck) begin
          // Completion wins over a simultaneous timeout.
          wb_d       = WBIn;
          valid_d    = 1'b1;
          mem_data_d = mem_we_q ? {DW{1'b0}} : MemRData;
          alu_d      = AluOutIn;
          treg_d     = TRegIn;
          mem_req_d  = 1'b0;
          state_d    = S_IDLE;
        end else if (timeout_s) begin
          // Abort: retire the instruction with its register write suppressed.
          wb_d       = 2'b00;
          valid_d    = 1'b1;
          mem_data_d = {DW{1'b0}};
          alu_d      = AluOutIn;
          treg_d     = TRegIn;
          mem_req_d  = 1'b0;
          state_d    = S_IDLE;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // FSM state, memory port and MEM/WB registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {DW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
      wb_q        <= 2'b00;
      valid_q     <= 1'b0;
      mem_data_q  <= {DW{1'b0}};
      alu_q       <= {DW{1'b0}};
      treg_q      <= {RW{1'b0}};
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_q        <= wb_d;
      valid_q     <= valid_d;
      mem_data_q  <= mem_data_d;
      alu_q       <= alu_d;
      treg_q      <= treg_d;
    end
  end

  // Branch resolution is suppressed while an access is in flight.
  assign PCSrc        = MIn[2] & ZeroIn & (state_q != S_ACCESS);
  assign BranchTarget = PcAddIn;
  assign Stall        = stall_s;
  assign MemReq       = mem_req_q;
  assign MemWe        = mem_we_q;
  assign MemAddr      = mem_addr_q;
  assign MemWData     = mem_wdata_q;
  assign WBOut        = wb_q;
  assign ValidOut     = valid_q;
  assign MemDataOut   = mem_data_q;
  assign AluOutOut    = alu_q;
  assign TRegOut      = treg_q;

endmodule
